// File: rtl/bresenham_pkg.sv
// Shared types for the Bresenham line front end: command record, scheduler states.
package bresenham_pkg;

  localparam int COORD_W = 8;

  // One queued line command as it sits in the FIFO.
  typedef struct packed {
    logic               clear;
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
  } line_cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_START,
    S_WAIT,
    S_GAP
  } sched_state_t;

  // Pack a requester's clear flag and {x0,y0,x1,y1} word into a command.
  function automatic line_cmd_t make_cmd(input logic clr, input logic [4*COORD_W-1:0] coords);
    return line_cmd_t'({clr, coords});
  endfunction

endpackage

// File: rtl/line_cmd_fifo.sv
// DEPTH-entry command FIFO; head entry is visible on rd_data while not empty.
module line_cmd_fifo
  import bresenham_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  line_cmd_t wr_data,
  input  logic      pop,
  output line_cmd_t rd_data,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  line_cmd_t     mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          wr_en;
  logic          rd_en;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign wr_en   = push && !full;
  assign rd_en   = pop && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Read/write pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/line_draw_scheduler.sv
// Round-robin command intake, FIFO buffering and one-line-at-a-time engine sequencing.
module line_draw_scheduler
  import bresenham_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 512
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_clear,
  input  logic [NREQ-1:0][31:0]    req_coords,
  output logic [NREQ-1:0]          req_ready,
  output logic [COORD_W-1:0]       eng_x0,
  output logic [COORD_W-1:0]       eng_y0,
  output logic [COORD_W-1:0]       eng_x1,
  output logic [COORD_W-1:0]       eng_y1,
  output logic                     eng_reset_buff,
  output logic                     eng_start,
  input  logic                     eng_done,
  output logic                     busy,
  output logic                     timeout_err,
  output logic [15:0]              lines_drawn
);

  localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WCW = $clog2(TIMEOUT + 1);

  logic [RRW-1:0] rr_ptr;
  logic [RRW-1:0] gnt_idx;
  logic           gnt_found;
  logic [NREQ-1:0] gnt;

  line_cmd_t      push_cmd;
  line_cmd_t      head_cmd;
  line_cmd_t      cmd_q;
  logic           fifo_full;
  logic           fifo_empty;
  logic           push;
  logic           pop;

  sched_state_t   state;
  logic [WCW-1:0] wait_cnt;

  // Round-robin pick: first valid requester at or after rr_ptr, nothing when full.
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    if (!fifo_full) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!gnt_found && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
          gnt_found = 1'b1;
          gnt_idx   = RRW'((int'(rr_ptr) + k) % NREQ);
        end
      end
    end
    if (gnt_found) gnt[gnt_idx] = 1'b1;
  end

  assign req_ready = gnt;
  assign push      = gnt_found;
  assign push_cmd  = make_cmd(req_clear[gnt_idx], req_coords[gnt_idx]);
  assign pop       = (state == S_IDLE) && !fifo_empty;
  assign busy      = !fifo_empty || (state != S_IDLE);

  // Advance the round-robin pointer past whoever was just granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (push) begin
      rr_ptr <= (gnt_idx == RRW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  line_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (push_cmd),
    .pop     (pop),
    .rd_data (head_cmd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Engine sequencer: pulses are set on entry to CLEAR/START so they are high for exactly that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      cmd_q          <= '0;
      eng_x0         <= '0;
      eng_y0         <= '0;
      eng_x1         <= '0;
      eng_y1         <= '0;
      eng_reset_buff <= 1'b0;
      eng_start      <= 1'b0;
      wait_cnt       <= '0;
      timeout_err    <= 1'b0;
      lines_drawn    <= '0;
    end else begin
      eng_reset_buff <= 1'b0;
      eng_start      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            cmd_q <= head_cmd;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          eng_x0 <= cmd_q.x0;
          eng_y0 <= cmd_q.y0;
          eng_x1 <= cmd_q.x1;
          eng_y1 <= cmd_q.y1;
          if (cmd_q.clear) begin
            eng_reset_buff <= 1'b1;
            state          <= S_CLEAR;
          end else begin
            eng_start <= 1'b1;
            state     <= S_START;
          end
        end
        S_CLEAR: begin
          eng_start <= 1'b1;
          state     <= S_START;
        end
        S_START: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (eng_done) begin
            lines_drawn <= lines_drawn + 16'd1;
            state       <= S_GAP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == WCW'(TIMEOUT - 1)) begin
              // Engine hung: drop this line and move on.
              timeout_err <= 1'b1;
              state       <= S_GAP;
            end
          end
        end
        S_GAP: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_draw_scheduler.sv
// Directed bench for line_draw_scheduler with a small engine model answering eng_start.
module tb_line_draw_scheduler;

  logic              clk;
  logic              rst;
  logic [1:0]        req_valid;
  logic [1:0]        req_clear;
  logic [1:0][31:0]  req_coords;
  logic [1:0]        req_ready;
  logic [7:0]        eng_x0, eng_y0, eng_x1, eng_y1;
  logic              eng_reset_buff;
  logic              eng_start;
  logic              eng_done;
  logic              busy;
  logic              timeout_err;
  logic [15:0]       lines_drawn;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // engine model state
  int done_lat       = 20;
  int done_cnt       = -1;
  int start_cnt      = 0;
  int last_start_cyc = 0;
  int last_rb_cyc    = 0;
  int overlap        = 0;
  logic [31:0] start_q[$];

  line_draw_scheduler #(.NREQ(2), .DEPTH(4), .TIMEOUT(512)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_clear      (req_clear),
    .req_coords     (req_coords),
    .req_ready      (req_ready),
    .eng_x0         (eng_x0),
    .eng_y0         (eng_y0),
    .eng_x1         (eng_x1),
    .eng_y1         (eng_y1),
    .eng_reset_buff (eng_reset_buff),
    .eng_start      (eng_start),
    .eng_done       (eng_done),
    .busy           (busy),
    .timeout_err    (timeout_err),
    .lines_drawn    (lines_drawn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Engine model: eng_done pulses done_lat cycles after each eng_start (never if done_lat==0).
  always @(negedge clk) begin
    if (rst) begin
      eng_done = 1'b0;
      done_cnt = -1;
    end else begin
      eng_done = 1'b0;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) begin
          eng_done = 1'b1;
          done_cnt = -1;
        end
      end
      if (eng_start) begin
        start_cnt++;
        last_start_cyc = cyc;
        start_q.push_back({eng_x0, eng_y0, eng_x1, eng_y1});
        if (done_lat > 0) done_cnt = done_lat;
      end
      if (eng_reset_buff) last_rb_cyc = cyc;
      if (eng_start && eng_reset_buff) overlap++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a command on requester r until granted; acc = cycle of acceptance.
  task automatic push(input int r, input logic clr, input logic [31:0] c, output int acc);
    int b;
    acc = -1;
    b   = 0;
    @(negedge clk);
    req_valid[r]  = 1'b1;
    req_clear[r]  = clr;
    req_coords[r] = c;
    #1;
    while (!req_ready[r] && b < 2000) begin
      @(negedge clk); #1;
      b++;
    end
    if (b >= 2000) chk("push_grant_timeout", 32'(b), 32'd0);
    else acc = cyc;
    @(negedge clk);
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_start(output int sc);
    int b;
    b = 0;
    @(negedge clk);
    while (!eng_start && b < 2000) begin
      @(negedge clk);
      b++;
    end
    if (b >= 2000) chk("start_timeout", 32'(b), 32'd0);
    sc = cyc;
  endtask

  task automatic wait_lines(input logic [15:0] n, input int bound);
    int b;
    b = 0;
    while (lines_drawn != n && b < bound) begin
      @(negedge clk);
      b++;
    end
    if (b >= bound) chk("lines_timeout", 32'(lines_drawn), 32'(n));
  endtask

  localparam logic [31:0] C0 = 32'h0A0B0C0D;
  localparam logic [31:0] C1 = 32'h1A1B1C1D;
  localparam logic [31:0] C2 = 32'h2A2B2C2D;

  initial begin
    int acc, s, s2, te, sc, b;
    rst        = 1'b1;
    req_valid  = '0;
    req_clear  = '0;
    req_coords = '0;
    repeat (3) @(negedge clk);
    chk("rst_lines", 32'(lines_drawn), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'({eng_start, eng_reset_buff, timeout_err}), 32'd0);
    chk("rst_coords", {eng_x0, eng_y0, eng_x1, eng_y1}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: plain line (0,0)->(10,5)
    done_lat = 20;
    push(0, 1'b0, 32'h00000A05, acc);
    wait_start(s);
    chk("t1_start_lat", 32'(s - acc), 32'd3);
    chk("t1_coords", {eng_x0, eng_y0, eng_x1, eng_y1}, 32'h00000A05);
    wait_lines(16'd1, 100);
    chk("t1_done_cyc", 32'(cyc - s), 32'd21);
    chk("t1_coords_hold", {eng_x0, eng_y0, eng_x1, eng_y1}, 32'h00000A05);
    chk("t1_busy_gap", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t1_busy_idle", 32'(busy), 32'd0);

    // 2: clear before drawing
    push(1, 1'b1, 32'h01020304, acc);
    wait_start(s);
    chk("t2_start_lat", 32'(s - acc), 32'd4);
    chk("t2_rb_lat", 32'(last_rb_cyc - acc), 32'd3);
    chk("t2_coords", {eng_x0, eng_y0, eng_x1, eng_y1}, 32'h01020304);
    wait_lines(16'd2, 100);
    repeat (2) @(negedge clk);

    // 3: hold the engine busy, then fill the FIFO from both requesters
    done_lat = 200;
    push(1, 1'b0, 32'h11111111, acc);
    wait_start(s);
    req_coords[0] = C0;
    req_coords[1] = C1;
    req_clear     = '0;
    req_valid     = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("t3_grant", 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      @(negedge clk); #1;
    end
    chk("t3_full", 32'(req_ready), 32'd0);
    @(negedge clk); #1;
    chk("t3_full_hold", 32'(req_ready), 32'd0);

    // 4: pop while full must not accept in the same cycle
    req_valid = 2'b01;
    done_lat  = 5;
    wait_lines(16'd3, 400);
    chk("t4_full_gap", 32'(req_ready), 32'd0);
    req_coords[0] = C2;
    @(negedge clk); #1;
    chk("t4_pop_cycle", 32'(req_ready), 32'd0);
    @(negedge clk); #1;
    chk("t4_accept_next", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    wait_lines(16'd8, 400);
    chk("t4_start_total", 32'(start_q.size()), 32'd8);
    if (start_q.size() == 8) begin
      chk("t4_ord0", start_q[3], C0);
      chk("t4_ord1", start_q[4], C1);
      chk("t4_ord2", start_q[5], C0);
      chk("t4_ord3", start_q[6], C1);
      chk("t4_ord4", start_q[7], C2);
    end
    repeat (2) @(negedge clk);

    // 5: engine never answers -> timeout, next queued command still issued
    done_lat = 0;
    push(0, 1'b0, 32'h05060708, acc);
    wait_start(s);
    chk("t5_coords", {eng_x0, eng_y0, eng_x1, eng_y1}, 32'h05060708);
    push(0, 1'b0, 32'h090A0B0C, acc);
    b = 0;
    while (!timeout_err && b < 700) begin
      @(negedge clk);
      b++;
    end
    te = cyc;
    chk("t5_to_cyc", 32'(te - s), 32'd513);
    chk("t5_lines_same", 32'(lines_drawn), 32'd8);
    done_lat = 5;
    wait_start(s2);
    chk("t5_next_start", 32'(s2 - te), 32'd3);
    chk("t5_next_coords", {eng_x0, eng_y0, eng_x1, eng_y1}, 32'h090A0B0C);
    wait_lines(16'd9, 100);
    chk("t5_err_sticky", 32'(timeout_err), 32'd1);
    repeat (2) @(negedge clk);

    // 6: reset mid-WAIT with three commands queued
    done_lat = 0;
    push(0, 1'b0, 32'h10203040, acc);
    push(0, 1'b0, 32'h11213141, acc);
    push(0, 1'b0, 32'h12223242, acc);
    push(0, 1'b0, 32'h13233343, acc);
    repeat (3) @(negedge clk);
    chk("t6_busy_pre", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_coords", {eng_x0, eng_y0, eng_x1, eng_y1}, 32'd0);
    chk("t6_rst_flags", 32'({busy, eng_start, eng_reset_buff, timeout_err}), 32'd0);
    chk("t6_rst_lines", 32'(lines_drawn), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sc  = start_cnt;
    repeat (30) @(negedge clk);
    chk("t6_no_start", 32'(start_cnt), 32'(sc));
    chk("t6_idle", 32'(busy), 32'd0);
    done_lat = 5;
    push(1, 1'b0, 32'h3F3F0101, acc);
    wait_start(s);
    chk("t6_new_lat", 32'(s - acc), 32'd3);
    chk("t6_new_coords", {eng_x0, eng_y0, eng_x1, eng_y1}, 32'h3F3F0101);
    wait_lines(16'd1, 100);

    chk("no_overlap", 32'(overlap), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
